// File: rtl/bbox_resample.sv
// -----------------------------------------------------------------------------
// bbox_resample
//
// Purpose:
//   Re-reads the source image RAM over a previously found bounding box and
//   resamples the boxed region onto an OUT_N x OUT_N nearest-neighbour grid.
//   Each sample is thresholded to one bit and written into a tile RAM. Sample
//   coordinates come from running sums (px = i*w, py = j*h) scaled down by a
//   power-of-two shift, so there are no multipliers or dividers.
//
// Handshake:
//   start is a one-cycle request, accepted only while the FSM is in IDLE or
//   DONE. The box inputs are captured on the accepted edge and may change
//   afterwards. busy is high from acceptance to completion; done is a level
//   that stays high until the next accepted start; err qualifies done.
//
// Ports:
//   CLOCK_50   in   rising-edge clock
//   KEY[3]     in   asynchronous active-low reset (KEY[2:0] unused)
//   start      in   run request
//   xMin..yMax in   inclusive box corners
//   src_addr   out  source read address {sy, sx}
//   src_data   in   synchronous RAM data, valid one cycle after src_addr
//   tile_we    out  tile write strobe, one cycle per sample
//   tile_addr  out  tile address {j, i}
//   tile_bit   out  thresholded sample
//   busy       out  run in progress
//   done       out  run finished
//   err        out  degenerate box (xMax<xMin or yMax<yMin)
// -----------------------------------------------------------------------------
module bbox_resample #(
    parameter int SRC_W  = 128,
    parameter int SRC_H  = 128,
    parameter int PIX_W  = 8,
    parameter int OUT_N  = 16,
    parameter int THRESH = 128
) (
    input  logic                           CLOCK_50,
    input  logic [3:0]                     KEY,
    input  logic                           start,
    input  logic [$clog2(SRC_W)-1:0]       xMin,
    input  logic [$clog2(SRC_W)-1:0]       yMin,
    input  logic [$clog2(SRC_W)-1:0]       xMax,
    input  logic [$clog2(SRC_W)-1:0]       yMax,
    output logic [$clog2(SRC_W*SRC_H)-1:0] src_addr,
    input  logic [PIX_W-1:0]               src_data,
    output logic                           tile_we,
    output logic [2*$clog2(OUT_N)-1:0]     tile_addr,
    output logic                           tile_bit,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int CW    = $clog2(SRC_W);        // coordinate width
    localparam int LN    = $clog2(OUT_N);        // tile index width
    localparam int ACC_W = CW + LN;              // running-sum width
    localparam int AW    = $clog2(SRC_W*SRC_H);  // source address width
    localparam int RW    = AW - CW;              // row part of the address
    localparam int TW    = 2 * LN;               // tile address width

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    logic rst_n;
    assign rst_n = KEY[3];

    // KEY[2:0] have no function in this block.
    logic unused_keys;
    assign unused_keys = ^KEY[2:0];

    state_t            state_q,    state_d;
    logic [CW-1:0]     x_min_q,    x_min_d;
    logic [CW-1:0]     y_min_q,    y_min_d;
    logic [CW-1:0]     x_max_q,    x_max_d;
    logic [CW-1:0]     y_max_q,    y_max_d;
    logic [CW:0]       w_q,        w_d;
    logic [CW:0]       h_q,        h_d;
    logic [LN-1:0]     i_q,        i_d;
    logic [LN-1:0]     j_q,        j_d;
    logic [ACC_W-1:0]  px_q,       px_d;
    logic [ACC_W-1:0]  py_q,       py_d;
    logic [AW-1:0]     src_addr_q, src_addr_d;
    logic              tile_we_q,  tile_we_d;
    logic [TW-1:0]     tile_addr_q, tile_addr_d;
    logic              tile_bit_q, tile_bit_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    // Raster step from the current sample to the next one. The source address
    // of the next sample is formed from these stepped values so that src_addr
    // is already stable for the whole ADDR cycle.
    logic              last_col;
    logic              last_pix;
    logic [LN-1:0]     i_n;
    logic [LN-1:0]     j_n;
    logic [ACC_W-1:0]  px_n;
    logic [ACC_W-1:0]  py_n;
    logic [CW-1:0]     sx_n;
    logic [CW-1:0]     sy_n;
    logic [CW:0]       w_calc;
    logic [CW:0]       h_calc;
    logic              box_bad;

    assign last_col = (i_q == LN'(OUT_N - 1));
    assign last_pix = last_col && (j_q == LN'(OUT_N - 1));
    assign i_n      = last_col ? '0 : i_q + 1'b1;
    assign j_n      = last_col ? j_q + 1'b1 : j_q;
    assign px_n     = last_col ? '0 : px_q + ACC_W'(w_q);
    assign py_n     = last_col ? py_q + ACC_W'(h_q) : py_q;
    // Dropping the low LN bits divides by OUT_N; the result stays within
    // the box because (OUT_N-1)*w/OUT_N < w.
    assign sx_n     = x_min_q + px_n[ACC_W-1:LN];
    assign sy_n     = y_min_q + py_n[ACC_W-1:LN];

    assign w_calc   = {1'b0, x_max_q} - {1'b0, x_min_q} + 1'b1;
    assign h_calc   = {1'b0, y_max_q} - {1'b0, y_min_q} + 1'b1;
    assign box_bad  = (x_max_q < x_min_q) || (y_max_q < y_min_q);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_min_q     <= '0;
            y_min_q     <= '0;
            x_max_q     <= '0;
            y_max_q     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            src_addr_q  <= '0;
            tile_we_q   <= 1'b0;
            tile_addr_q <= '0;
            tile_bit_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_min_q     <= x_min_d;
            y_min_q     <= y_min_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            w_q         <= w_d;
            h_q         <= h_d;
            i_q         <= i_d;
            j_q         <= j_d;
            px_q        <= px_d;
            py_q        <= py_d;
            src_addr_q  <= src_addr_d;
            tile_we_q   <= tile_we_d;
            tile_addr_q <= tile_addr_d;
            tile_bit_q  <= tile_bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_min_d     = x_min_q;
        y_min_d     = y_min_q;
        x_max_d     = x_max_q;
        y_max_d     = y_max_q;
        w_d         = w_q;
        h_d         = h_q;
        i_d         = i_q;
        j_d         = j_q;
        px_d        = px_q;
        py_d        = py_q;
        src_addr_d  = src_addr_q;
        tile_we_d   = 1'b0;
        tile_addr_d = tile_addr_q;
        tile_bit_d  = tile_bit_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CHECK;
                    x_min_d = xMin;
                    y_min_d = yMin;
                    x_max_d = xMax;
                    y_max_d = yMax;
                    i_d     = '0;
                    j_d     = '0;
                    px_d    = '0;
                    py_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            S_CHECK: begin
                if (box_bad) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d    = S_ADDR;
                    w_d        = w_calc;
                    h_d        = h_calc;
                    // First sample sits at the top-left corner of the box.
                    src_addr_d = {RW'(y_min_q), x_min_q};
                end
            end

            S_ADDR: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // The RAM word for src_addr is on src_data now; capture it
                // together with the strobe so the write cycle is a pure flop.
                state_d     = S_WRITE;
                tile_we_d   = 1'b1;
                tile_addr_d = {j_q, i_q};
                tile_bit_d  = (src_data >= PIX_W'(THRESH));
            end

            S_WRITE: begin
                if (last_pix) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_ADDR;
                    i_d        = i_n;
                    j_d        = j_n;
                    px_d       = px_n;
                    py_d       = py_n;
                    src_addr_d = {RW'(sy_n), sx_n};
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign src_addr  = src_addr_q;
    assign tile_we   = tile_we_q;
    assign tile_addr = tile_addr_q;
    assign tile_bit  = tile_bit_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
